// File: rtl/wshb_mire_if.sv
`default_nettype none
// ============================================================================
// Module   : wshb_mire_if
// Brief    : 16-bit Wishbone write-master bundle for the test-pattern painter.
// Revision : 1.0
// ============================================================================
interface wshb_mire_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [15:0] wb_dat_ms;
    logic [1:0]  wb_sel;
    logic        wb_ack;

    modport master (
        output wb_cyc,
        output wb_stb,
        output wb_we,
        output wb_adr,
        output wb_dat_ms,
        output wb_sel,
        input  wb_ack
    );

    modport slave (
        input  wb_cyc,
        input  wb_stb,
        input  wb_we,
        input  wb_adr,
        input  wb_dat_ms,
        input  wb_sel,
        output wb_ack
    );
endinterface
`default_nettype wire

// File: rtl/wshb_mire.sv
`default_nettype none
// ============================================================================
// Module   : wshb_mire
// Brief    : Wishbone master painting a grid test pattern into the frame
//            buffer, one pixel per transaction, releasing the bus each burst.
// Revision : 1.0
// ============================================================================
module wshb_mire #(
    parameter int HDISP = 640,
    parameter int VDISP = 480,
    parameter int BURST = 64,
    parameter int PAUSE = 2,
    parameter int GRID  = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    wshb_mire_if.master wb,
    output logic        frame_done
);

    localparam int c_XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int c_YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int c_BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int c_PW = (PAUSE > 1) ? $clog2(PAUSE) : 1;

    localparam logic [c_XW-1:0] c_X_LAST     = c_XW'(HDISP - 1);
    localparam logic [c_YW-1:0] c_Y_LAST     = c_YW'(VDISP - 1);
    localparam logic [c_XW-1:0] c_X_MASK     = c_XW'(GRID - 1);
    localparam logic [c_YW-1:0] c_Y_MASK     = c_YW'(GRID - 1);
    localparam logic [c_BW-1:0] c_BURST_LAST = c_BW'(BURST - 1);
    localparam logic [c_PW-1:0] c_PAUSE_LAST = c_PW'(PAUSE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state;
    logic [c_XW-1:0] r_x;
    logic [c_XW-1:0] w_x;
    logic [c_YW-1:0] r_y;
    logic [c_YW-1:0] w_y;
    logic [31:0]     r_adr;
    logic [31:0]     w_adr;
    logic [c_BW-1:0] r_burst;
    logic [c_BW-1:0] w_burst;
    logic [c_PW-1:0] r_pause;
    logic [c_PW-1:0] w_pause;
    logic            r_stb;
    logic            w_stb;
    logic [15:0]     r_dat;
    logic            r_frame_done;
    logic            w_frame_done;

    logic            w_last_x;
    logic            w_last_y;

    // Grid lines fall on multiples of GRID; GRID is a power of two so a mask suffices.
    function automatic logic [15:0] f_pixel(input logic [c_XW-1:0] px,
                                            input logic [c_YW-1:0] py);
        return (((px & c_X_MASK) == '0) || ((py & c_Y_MASK) == '0)) ? 16'hFFFF : 16'h0000;
    endfunction

    assign w_last_x = (r_x == c_X_LAST);
    assign w_last_y = (r_y == c_Y_LAST);

    always_comb begin
        w_state      = r_state;
        w_x          = r_x;
        w_y          = r_y;
        w_adr        = r_adr;
        w_burst      = r_burst;
        w_pause      = r_pause;
        w_stb        = r_stb;
        w_frame_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state = S_WRITE;
                    w_stb   = 1'b1;
                end
            end

            S_WRITE: begin
                if (wb.wb_ack) begin
                    if (!w_last_x) begin
                        w_x   = r_x + c_XW'(1);
                        w_adr = r_adr + 32'd2;
                    end else if (!w_last_y) begin
                        w_x   = '0;
                        w_y   = r_y + c_YW'(1);
                        w_adr = r_adr + 32'd2;
                    end else begin
                        w_x          = '0;
                        w_y          = '0;
                        w_adr        = '0;
                        w_frame_done = 1'b1;
                    end

                    // Burst boundary wins over a disable on the same ack.
                    if (r_burst == c_BURST_LAST) begin
                        w_burst = '0;
                        w_pause = '0;
                        w_state = S_PAUSE;
                        w_stb   = 1'b0;
                    end else begin
                        w_burst = r_burst + c_BW'(1);
                        if (!enable) begin
                            w_state = S_IDLE;
                            w_stb   = 1'b0;
                        end
                    end
                end
            end

            S_PAUSE: begin
                if (r_pause == c_PAUSE_LAST) begin
                    w_state = enable ? S_WRITE : S_IDLE;
                    w_stb   = enable;
                end else begin
                    w_pause = r_pause + c_PW'(1);
                end
            end

            default: begin
                w_state = S_IDLE;
                w_stb   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_adr        <= '0;
            r_burst      <= '0;
            r_pause      <= '0;
            r_stb        <= 1'b0;
            r_dat        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_x          <= w_x;
            r_y          <= w_y;
            r_adr        <= w_adr;
            r_burst      <= w_burst;
            r_pause      <= w_pause;
            r_stb        <= w_stb;
            r_dat        <= f_pixel(w_x, w_y);
            r_frame_done <= w_frame_done;
        end
    end

    assign wb.wb_cyc    = r_stb;
    assign wb.wb_stb    = r_stb;
    assign wb.wb_we     = r_stb;
    assign wb.wb_sel    = {2{r_stb}};
    assign wb.wb_adr    = r_adr;
    assign wb.wb_dat_ms = r_dat;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_wshb_mire.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_mire
// Brief    : Randomised self-checking bench for wshb_mire against a pixel-level
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_wshb_mire;
    localparam int HDISP = 32;
    localparam int VDISP = 4;
    localparam int BURST = 8;
    localparam int PAUSE = 2;
    localparam int GRID  = 16;
    localparam int NPIX  = HDISP * VDISP;

    logic clk    = 1'b0;
    logic nrst   = 1'b0;
    logic enable = 1'b0;
    logic frame_done;

    wshb_mire_if bus();

    wshb_mire #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .BURST (BURST),
        .PAUSE (PAUSE),
        .GRID  (GRID)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .enable     (enable),
        .wb         (bus),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_errors   = 0;

    // Reference model: which pixel is on the bus, and whether the bus is held.
    bit m_busy;
    int m_gap;
    int m_pix;
    int m_burst;
    bit m_fd;
    int m_frames   = 0;
    int obs_frames = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_dat(input int p);
        int x;
        int y;
        x = p % HDISP;
        y = p / HDISP;
        return ((x % GRID) == 0 || (y % GRID) == 0) ? 16'hFFFF : 16'h0000;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_gap   = 0;
        m_pix   = 0;
        m_burst = 0;
        m_fd    = 1'b0;
    endtask

    // One bus cycle: check what is visible now, then drive inputs for the next edge.
    task automatic step(input logic a, input logic e, input logic r);
        @(negedge clk);
        check("frame_done", frame_done, m_fd);
        if (frame_done) obs_frames++;
        check("cyc", bus.wb_cyc, m_busy);
        check("stb", bus.wb_stb, m_busy);
        if (m_busy) begin
            check("we", bus.wb_we, 1);
            check("sel", bus.wb_sel, 2'b11);
            check("adr", bus.wb_adr, 32'(2 * m_pix));
            check("dat", bus.wb_dat_ms, exp_dat(m_pix));
        end

        bus.wb_ack = a;
        enable     = e;
        nrst       = r;

        m_fd = 1'b0;
        if (!r) begin
            model_reset();
        end else if (m_busy) begin
            if (a) begin
                if (m_pix == NPIX - 1) begin
                    m_fd = 1'b1;
                    m_frames++;
                end
                m_pix = (m_pix + 1) % NPIX;
                m_burst++;
                if (m_burst == BURST) begin
                    m_burst = 0;
                    m_busy  = 1'b0;
                    m_gap   = PAUSE;
                end else if (!e) begin
                    m_busy = 1'b0;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_busy = e;
        end else begin
            m_busy = e;
        end
    endtask

    initial begin
        int   wait_cnt;
        int   k;
        int   p_saved;
        logic a;

        bus.wb_ack = 1'b0;
        enable     = 1'b1;
        nrst       = 1'b0;
        wait_cnt   = 0;
        model_reset();

        // Held in reset with enable high: nothing may move.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        check("rst_adr", bus.wb_adr, 0);
        check("rst_dat", bus.wb_dat_ms, 0);
        check("rst_sel", bus.wb_sel, 0);
        check("rst_we", bus.wb_we, 0);

        // Ack held high: back-to-back writes, burst releases, frame wraps.
        for (int i = 0; i < 320; i++) step(1'b1, 1'b1, 1'b1);

        // Random ack latency 0..3, with ack noise while the strobe is low.
        for (int i = 0; i < 900; i++) begin
            if (m_busy) begin
                if (wait_cnt == 0) begin
                    a        = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    a = 1'b0;
                    wait_cnt--;
                end
            end else begin
                a = 1'($urandom_range(0, 1));
            end
            step(a, 1'b1, 1'b1);
        end

        // Drop enable while a strobe waits for its ack.
        k = 0;
        while (!m_busy && k < 20) begin
            step(1'b0, 1'b1, 1'b1);
            k++;
        end
        check("stb_wait_timeout", 32'(k < 20), 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        p_saved = m_pix;
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("resume_adr", bus.wb_adr, 32'(2 * p_saved));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a pending transaction.
        k = 0;
        while (!m_busy && k < 20) begin
            step(1'b0, 1'b1, 1'b1);
            k++;
        end
        step(1'b0, 1'b1, 1'b1);
        check("pre_rst_stb", bus.wb_stb, 1);
        #2 nrst = 1'b0;
        #1;
        check("async_cyc", bus.wb_cyc, 0);
        check("async_stb", bus.wb_stb, 0);
        model_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("restart_adr", bus.wb_adr, 0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b1);

        // Stop and let any last pulse become visible.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
        check("frame_count", obs_frames, m_frames);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wshb_mire.md
# wshb_mire

Wishbone master that paints a test-pattern grid into the SDRAM frame buffer. It sits upstream of the VGA reader on the same 16-bit Wishbone bus, which is clocked by `wshb_clk`. It writes one 16-bit pixel per transaction, walking the frame linearly, and voluntarily drops `cyc` every `BURST` pixels so an arbiter can serve the display reader. It can repaint continuously, or stop between frames under control of `enable`.

## Interface
Parameters:
- `HDISP`, 640, pixels per line
- `VDISP`, 480, lines per frame
- `BURST`, 64, acked writes before a bus release
- `PAUSE`, 2, cycles `cyc` stays low during a release (≥1)
- `GRID`, 16, grid pitch in pixels (power of two)

Ports:
- `clk`  in  1  bus clock (`wshb_clk`)
- `nrst`  in  1  reset; asynchronous, active-low
- `enable`  in  1  level; high = paint
- `wb_cyc`  out  1  bus cycle
- `wb_stb`  out  1  strobe
- `wb_we`  out  1  write enable, constant 1 while `wb_stb`
- `wb_adr`  out  32  byte address
- `wb_dat_ms`  out  16  write data
- `wb_sel`  out  2  byte lanes, constant 2'b11 while `wb_stb`
- `wb_ack`  in  1  slave acknowledge
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is acked

## Operation
- Position registers: `x` in 0..HDISP-1 and `y` in 0..VDISP-1, plus a linear byte address `adr`. `adr` increments by 2 per acked pixel. No multiplier is used.
- `wb_adr = adr`, where `adr = 2*(y*HDISP + x)`.
- Pixel value: 16'hFFFF if `x[log2 GRID-1:0]==0` or `y[log2 GRID-1:0]==0`; otherwise 16'h0000.
- States: IDLE, WRITE, PAUSE.
  - IDLE: `cyc=stb=0`. Moves to WRITE when `enable` is sampled high.
  - WRITE: `cyc=stb=1` with stable `adr` and `dat` until `wb_ack`. On ack:
    - advance `x`; on line end set `x` to 0 and increment `y`; on frame end set `x`, `y` and `adr` to 0;
    - increment the burst count.
    - Next state on the same ack:
      - burst count reaches BURST: go to PAUSE and clear the burst count;
      - otherwise, `enable` low: go to IDLE;
      - otherwise: stay in WRITE.
  - PAUSE: `cyc=stb=0` for exactly PAUSE cycles. Then go to WRITE if `enable` is high, else IDLE.
- `enable` dropping mid-transaction: the current `stb` is held until its ack; the pixel is counted, then the block goes to IDLE.
- Position and burst count are retained in IDLE, so painting resumes at the next pixel.
- Frame wrap: `frame_done` pulses high in the cycle after the ack of pixel (HDISP-1, VDISP-1), coinciding with the post-ack state. If `enable` is high, painting continues at pixel (0,0) with no extra gap unless the burst boundary coincides.
- If a frame end and a burst boundary coincide, both take effect: `frame_done` pulses and the block enters PAUSE.
- `wb_ack` while `stb=0` is ignored.

## Timing
- Reset (async assert on `nrst` low, while low): state=IDLE; `x=y=adr=0`; burst count=0; `wb_cyc=wb_stb=wb_we=0`; `wb_adr=0`; `wb_dat_ms=0`; `wb_sel=0`; `frame_done=0`.
- Reset mid-transaction aborts immediately; the bus is released asynchronously.
- `enable` sampled high at edge n: `cyc/stb` are high after edge n (visible in cycle n+1).
- Ack sampled at edge k with the block continuing:
  - the next pixel's `adr` and `dat` are valid after edge k;
  - `stb` stays high with no idle cycle, giving a throughput of 1 pixel per cycle when ack is held high.
- All outputs are registered; no combinational path from `wb_ack` or `enable` to outputs.
- Latency, ack to `frame_done`: 1 edge.

## Test plan
Sim parameters: HDISP=32, VDISP=4, BURST=8, PAUSE=2, GRID=16.
- Reset with `enable=1`, then release `nrst` and hold ack high -> cycle after first edge: `cyc=stb=we=1`, `adr=0`, `dat=FFFF`, `sel=11`. Subsequent pixels: `adr` 2, 4, …; pixel `x=1` gives `dat=0000`.
- Pattern check over a full frame with random ack delays of 0..3 cycles -> every write at `adr` 2*(y*32+x):
  - `dat=FFFF` exactly when `x∈{0,16}` or `y=0`;
  - no address skipped or repeated;
  - `adr/dat` stable while `stb` is high and ack is low.
- Burst release, ack always high -> after 8 acks, `cyc` low for exactly 2 cycles, then it resumes at `adr=16`.
- Frame wrap -> ack of `adr=254` is followed by a 1-cycle `frame_done`, the next write at `adr=0`, and exactly 1 pulse per 128 pixels.
- Drop `enable` while `stb` is high and ack is low, then ack 3 cycles later -> the pixel completes, `cyc=0` the next cycle, and the block stays idle. Re-raise `enable` -> the next write is at the following address.
- Pull `nrst` low mid-transaction -> `cyc/stb` drop without waiting for a clock edge. After release, painting restarts at `adr=0` with no `frame_done`.
